// File: rtl/sum_fact_pkg.sv
// -----------------------------------------------------------------------------
// sum_fact_pkg
// Shared widths, state encoding and small helpers for the sum-of-factorial
// request driver (sum_fact_driver) and its watchdog.
// -----------------------------------------------------------------------------
package sum_fact_pkg;

  localparam int N_W   = 3;   // operand width
  localparam int SUM_W = 13;  // result width
  localparam int ERR_W = 4;   // timeout counter width

  localparam logic [N_W-1:0]   N_ZERO  = N_W'(0);
  localparam logic [N_W-1:0]   N_ONE   = N_W'(1);
  localparam logic [N_W-1:0]   N_MAX   = N_W'(7);
  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(15);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ACK     = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  // Operand 0 never terminates in the responder, so it is promoted to 1.
  function automatic logic [N_W-1:0] clamp_first(input logic [N_W-1:0] n);
    return (n == N_ZERO) ? N_ONE : n;
  endfunction

  // Saturating increment for the per-sweep timeout counter.
  function automatic logic [ERR_W-1:0] err_inc(input logic [ERR_W-1:0] e);
    return (e == ERR_MAX) ? e : (e + ERR_ONE);
  endfunction

endpackage

// File: rtl/sum_fact_watchdog.sv
// -----------------------------------------------------------------------------
// sum_fact_watchdog
// Counts enabled cycles since the last clear. 'expired' is high during the
// TIMEOUT-th enabled cycle after a clear, so a wait that is enabled from its
// first cycle lasts exactly TIMEOUT cycles before it is declared hung.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   clear       : restart the count at zero
//   enable      : count this cycle
//   expired     : the current enabled cycle is the TIMEOUT-th one
// -----------------------------------------------------------------------------
module sum_fact_watchdog #(
  parameter int TIMEOUT = 31
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] count_r;

  // Cycle counter, saturating at its maximum so it can never wrap back to LIMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= 8'd0;
    end else if (clear) begin
      count_r <= 8'd0;
    end else if (enable && (count_r != 8'hFF)) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = enable && (count_r == LIMIT);

endmodule

// File: rtl/sum_fact_driver.sv
// -----------------------------------------------------------------------------
// sum_fact_driver
// Initiator for a sum_fact_N-style responder. Sweeps operands n_first..n_last,
// issuing one single-cycle request per operand, acknowledging each response
// and reporting it on a registered result port. A watchdog turns a hung
// request into a timeout result and pulses peer_clear at the responder.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start, n_first, n_last: sweep request, sampled only when idle
//   req_n, req_valid      : operand and strobe to the responder
//   rsp_sum, rsp_valid    : responder result and valid
//   rsp_ack               : responder acknowledge
//   peer_clear            : one-cycle responder clear after a timeout
//   res_n, res_sum        : reported operand/result (held until next report)
//   res_valid, res_timeout: report strobe and its timeout qualifier
//   err_count             : timeouts this sweep, saturating
//   busy, done            : sweep in progress / completion pulse
// -----------------------------------------------------------------------------
module sum_fact_driver
  import sum_fact_pkg::*;
#(
  parameter int TIMEOUT = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N_W-1:0]   n_first,
  input  logic [N_W-1:0]   n_last,
  output logic [N_W-1:0]   req_n,
  output logic             req_valid,
  input  logic [SUM_W-1:0] rsp_sum,
  input  logic             rsp_valid,
  output logic             rsp_ack,
  output logic             peer_clear,
  output logic [N_W-1:0]   res_n,
  output logic [SUM_W-1:0] res_sum,
  output logic             res_valid,
  output logic             res_timeout,
  output logic [ERR_W-1:0] err_count,
  output logic             busy,
  output logic             done
);

  state_t             state_r, state_s;
  logic [N_W-1:0]     cur_n_r, cur_n_s;
  logic [N_W-1:0]     last_n_r, last_n_s;
  logic [N_W-1:0]     first_s;
  logic [N_W-1:0]     req_n_r;
  logic               req_valid_r, rsp_ack_r, peer_clear_r;
  logic               peer_clear_s;
  logic [N_W-1:0]     res_n_r, res_n_s;
  logic [SUM_W-1:0]   res_sum_r, res_sum_s;
  logic               res_valid_r, res_valid_s;
  logic               res_timeout_r, res_timeout_s;
  logic [ERR_W-1:0]   err_count_r, err_count_s;
  logic               busy_r, done_r, done_s;
  logic               wd_clear_s, wd_enable_s, wd_expired_s;

  assign first_s     = clamp_first(n_first);
  assign wd_clear_s  = (state_r == ST_ISSUE);
  assign wd_enable_s = (state_r == ST_WAIT);

  sum_fact_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear_s),
    .enable  (wd_enable_s),
    .expired (wd_expired_s)
  );

  // Next-state and next-register values for the sweep FSM.
  always_comb begin
    state_s       = state_r;
    cur_n_s       = cur_n_r;
    last_n_s      = last_n_r;
    res_n_s       = res_n_r;
    res_sum_s     = res_sum_r;
    res_valid_s   = 1'b0;
    res_timeout_s = 1'b0;
    peer_clear_s  = 1'b0;
    err_count_s   = err_count_r;
    done_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s     = ST_ISSUE;
          cur_n_s     = first_s;
          // A reversed range degenerates to a single request for first.
          last_n_s    = (n_last < first_s) ? first_s : n_last;
          err_count_s = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        // A response arriving on the expiry cycle still counts as a response.
        if (rsp_valid) begin
          state_s     = ST_ACK;
          res_valid_s = 1'b1;
          res_n_s     = cur_n_r;
          res_sum_s   = rsp_sum;
        end else if (wd_expired_s) begin
          state_s       = ST_RELEASE;
          res_valid_s   = 1'b1;
          res_timeout_s = 1'b1;
          res_n_s       = cur_n_r;
          res_sum_s     = '0;
          peer_clear_s  = 1'b1;
          err_count_s   = err_inc(err_count_r);
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_ACK: begin
        state_s = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!rsp_valid) begin
          // The N_MAX guard keeps cur_n from ever wrapping to 0.
          if ((cur_n_r == last_n_r) || (cur_n_r == N_MAX)) begin
            state_s = ST_IDLE;
            done_s  = 1'b1;
          end else begin
            state_s = ST_ISSUE;
            cur_n_s = cur_n_r + N_ONE;
          end
        end else begin
          state_s = ST_RELEASE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, range and result registers; strobes are decoded from the next state
  // so every output is a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      cur_n_r       <= '0;
      last_n_r      <= '0;
      req_n_r       <= '0;
      req_valid_r   <= 1'b0;
      rsp_ack_r     <= 1'b0;
      peer_clear_r  <= 1'b0;
      res_n_r       <= '0;
      res_sum_r     <= '0;
      res_valid_r   <= 1'b0;
      res_timeout_r <= 1'b0;
      err_count_r   <= '0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      cur_n_r       <= cur_n_s;
      last_n_r      <= last_n_s;
      req_n_r       <= (state_s == ST_ISSUE) ? cur_n_s : req_n_r;
      req_valid_r   <= (state_s == ST_ISSUE);
      rsp_ack_r     <= (state_s == ST_ACK);
      peer_clear_r  <= peer_clear_s;
      res_n_r       <= res_n_s;
      res_sum_r     <= res_sum_s;
      res_valid_r   <= res_valid_s;
      res_timeout_r <= res_timeout_s;
      err_count_r   <= err_count_s;
      busy_r        <= (state_s != ST_IDLE);
      done_r        <= done_s;
    end
  end

  assign req_n       = req_n_r;
  assign req_valid   = req_valid_r;
  assign rsp_ack     = rsp_ack_r;
  assign peer_clear  = peer_clear_r;
  assign res_n       = res_n_r;
  assign res_sum     = res_sum_r;
  assign res_valid   = res_valid_r;
  assign res_timeout = res_timeout_r;
  assign err_count   = err_count_r;
  assign busy        = busy_r;
  assign done        = done_r;

endmodule

// File: tb/tb_sum_fact_driver.sv
// -----------------------------------------------------------------------------
// tb_sum_fact_driver
// Directed bench for sum_fact_driver with a responder model that answers
// 100+N after a programmable latency and can be made silent for one operand.
// -----------------------------------------------------------------------------
module tb_sum_fact_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  n_first = 3'd0;
  logic [2:0]  n_last = 3'd0;
  logic [2:0]  req_n;
  logic        req_valid;
  logic [12:0] rsp_sum = 13'd0;
  logic        rsp_valid = 1'b0;
  logic        rsp_ack;
  logic        peer_clear;
  logic [2:0]  res_n;
  logic [12:0] res_sum;
  logic        res_valid;
  logic        res_timeout;
  logic [3:0]  err_count;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  sum_fact_driver #(.TIMEOUT(31)) dut (
    .clk(clk), .reset(reset), .start(start), .n_first(n_first), .n_last(n_last),
    .req_n(req_n), .req_valid(req_valid), .rsp_sum(rsp_sum), .rsp_valid(rsp_valid),
    .rsp_ack(rsp_ack), .peer_clear(peer_clear), .res_n(res_n), .res_sum(res_sum),
    .res_valid(res_valid), .res_timeout(res_timeout), .err_count(err_count),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Responder knobs
  int         lat = 4;
  bit         silent_en = 1'b0;
  logic [2:0] silent_n = 3'd0;

  // Event logs filled at the falling edge
  int          cyc = 0;
  int          req_cnt = 0, res_cnt = 0, ack_cnt = 0;
  int          done_cnt = 0, pclr_cnt = 0, dbl_req = 0, done_busy_bad = 0;
  logic [2:0]  req_n_log   [64];
  int          req_cyc_log [64];
  logic [2:0]  res_n_log   [64];
  logic [12:0] res_sum_log [64];
  logic        res_to_log  [64];
  int          res_cyc_log [64];
  int          ack_cyc_log [64];
  logic        prev_req = 1'b0;
  bit          pend = 1'b0;
  int          pcnt = 0;
  logic [2:0]  pn = 3'd0;

  // Monitor plus responder model, both away from the active edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (req_valid) begin
      if (prev_req) dbl_req = dbl_req + 1;
      if (req_cnt < 64) begin req_n_log[req_cnt] = req_n; req_cyc_log[req_cnt] = cyc; end
      req_cnt = req_cnt + 1;
    end
    prev_req = req_valid;
    if (res_valid) begin
      if (res_cnt < 64) begin
        res_n_log[res_cnt] = res_n; res_sum_log[res_cnt] = res_sum;
        res_to_log[res_cnt] = res_timeout; res_cyc_log[res_cnt] = cyc;
      end
      res_cnt = res_cnt + 1;
    end
    if (rsp_ack) begin
      if (ack_cnt < 64) ack_cyc_log[ack_cnt] = cyc;
      ack_cnt = ack_cnt + 1;
    end
    if (peer_clear) pclr_cnt = pclr_cnt + 1;
    if (done) begin
      done_cnt = done_cnt + 1;
      if (busy) done_busy_bad = done_busy_bad + 1;
    end
    if (reset || peer_clear) begin
      rsp_valid = 1'b0; pend = 1'b0;
    end else begin
      if (rsp_valid && rsp_ack) rsp_valid = 1'b0;
      if (req_valid) begin
        pend = 1'b1; pcnt = 0; pn = req_n;
      end else if (pend) begin
        pcnt = pcnt + 1;
        if (pcnt >= lat) begin
          pend = 1'b0;
          if (!(silent_en && pn == silent_n)) begin
            rsp_valid = 1'b1;
            rsp_sum = 13'd100 + {10'd0, pn};
          end
        end
      end
    end
  end

  // Start a sweep and wait (bounded) for done; edge_req is req_valid just after the start edge
  task automatic run_sweep(input logic [2:0] f, input logic [2:0] l, input int L,
                           output logic edge_req, output bit hung);
    int d0;
    lat = L;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; n_first = f; n_last = l;
    @(posedge clk); #1;
    edge_req = req_valid;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2000 && done_cnt == d0; i++) @(posedge clk);
    hung = (done_cnt == d0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({req_n, req_valid, rsp_ack, peer_clear, res_n, res_sum, res_valid, res_timeout,
         err_count, busy, done} !== 37'd0) begin
      fails++;
      $display("FAIL reset_outputs: got req_n=%0d rv=%0b ack=%0b pc=%0b res=(%0d,%0d) rsv=%0b to=%0b err=%0d busy=%0b done=%0b expected all 0",
               req_n, req_valid, rsp_ack, peer_clear, res_n, res_sum, res_valid, res_timeout, err_count, busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_sweep_basic();
    int rb, qb, ab, db, dq;
    logic e; bit h;
    logic [2:0]  en [3];
    logic [12:0] es [3];
    en = '{3'd1, 3'd2, 3'd3};
    es = '{13'd101, 13'd102, 13'd103};
    rb = res_cnt; qb = req_cnt; ab = ack_cnt; db = done_cnt; dq = dbl_req;
    run_sweep(3'd1, 3'd3, 4, e, h);
    tests++; if (e !== 1'b1) begin fails++; $display("FAIL basic_req_after_start: got %0b expected 1", e); end
    tests++; if (h) begin fails++; $display("FAIL basic_done_timeout: got no done expected done"); end
    tests++; if (res_cnt - rb != 3) begin fails++; $display("FAIL basic_res_count: got %0d expected 3", res_cnt - rb); end
    tests++; if (req_cnt - qb != 3) begin fails++; $display("FAIL basic_req_count: got %0d expected 3", req_cnt - qb); end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (res_n_log[rb+i] !== en[i] || res_sum_log[rb+i] !== es[i] || res_to_log[rb+i] !== 1'b0) begin
        fails++;
        $display("FAIL basic_res%0d: got (%0d,%0d,to=%0b) expected (%0d,%0d,to=0)",
                 i, res_n_log[rb+i], res_sum_log[rb+i], res_to_log[rb+i], en[i], es[i]);
      end
      tests++;
      if (req_n_log[qb+i] !== en[i]) begin
        fails++; $display("FAIL basic_req_n%0d: got %0d expected %0d", i, req_n_log[qb+i], en[i]);
      end
    end
    tests++; if (dbl_req != dq) begin fails++; $display("FAIL basic_single_strobe: got %0d double strobes expected 0", dbl_req - dq); end
    tests++; if (done_cnt - db != 1) begin fails++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt - db); end
    tests++; if (err_count !== 4'd0) begin fails++; $display("FAIL basic_err_count: got %0d expected 0", err_count); end
    tests++; if (res_cyc_log[rb] - req_cyc_log[qb] != 5) begin fails++; $display("FAIL basic_latency: got %0d expected 5", res_cyc_log[rb] - req_cyc_log[qb]); end
    tests++; if (ack_cyc_log[ab] != res_cyc_log[rb]) begin fails++; $display("FAIL basic_ack_with_res: got ack cyc %0d expected %0d", ack_cyc_log[ab], res_cyc_log[rb]); end
    tests++; if (req_cyc_log[qb+1] - ack_cyc_log[ab] != 2) begin fails++; $display("FAIL basic_ack_to_req: got %0d expected 2", req_cyc_log[qb+1] - ack_cyc_log[ab]); end
    tests++; if (res_n !== 3'd3 || res_sum !== 13'd103 || busy !== 1'b0) begin fails++; $display("FAIL basic_hold: got (%0d,%0d,busy=%0b) expected (3,103,busy=0)", res_n, res_sum, busy); end
  endtask

  task automatic test_clamp_zero();
    int rb, qb;
    logic e; bit h;
    rb = res_cnt; qb = req_cnt;
    run_sweep(3'd0, 3'd0, 4, e, h);
    tests++; if (h || req_cnt - qb != 1 || req_n_log[qb] !== 3'd1) begin fails++; $display("FAIL clamp_req: got hung=%0b count=%0d n=%0d expected hung=0 count=1 n=1", h, req_cnt - qb, req_n_log[qb]); end
    tests++; if (res_cnt - rb != 1 || res_n_log[rb] !== 3'd1 || res_sum_log[rb] !== 13'd101) begin fails++; $display("FAIL clamp_res: got count=%0d (%0d,%0d) expected count=1 (1,101)", res_cnt - rb, res_n_log[rb], res_sum_log[rb]); end
  endtask

  task automatic test_range_edges();
    int rb, qb;
    logic e; bit h;
    rb = res_cnt; qb = req_cnt;
    run_sweep(3'd6, 3'd2, 3, e, h);
    tests++; if (h || req_cnt - qb != 1 || req_n_log[qb] !== 3'd6) begin fails++; $display("FAIL reversed_req: got hung=%0b count=%0d n=%0d expected hung=0 count=1 n=6", h, req_cnt - qb, req_n_log[qb]); end
    tests++; if (res_n_log[rb] !== 3'd6 || res_sum_log[rb] !== 13'd106) begin fails++; $display("FAIL reversed_res: got (%0d,%0d) expected (6,106)", res_n_log[rb], res_sum_log[rb]); end
    rb = res_cnt; qb = req_cnt;
    run_sweep(3'd6, 3'd7, 3, e, h);
    repeat (40) @(posedge clk);
    tests++; if (h || req_cnt - qb != 2 || req_n_log[qb] !== 3'd6 || req_n_log[qb+1] !== 3'd7) begin fails++; $display("FAIL top_end_req: got hung=%0b count=%0d n0=%0d n1=%0d expected hung=0 count=2 n0=6 n1=7", h, req_cnt - qb, req_n_log[qb], req_n_log[qb+1]); end
    tests++; if (res_sum_log[rb] !== 13'd106 || res_sum_log[rb+1] !== 13'd107 || busy !== 1'b0) begin fails++; $display("FAIL top_end_res: got %0d,%0d busy=%0b expected 106,107 busy=0", res_sum_log[rb], res_sum_log[rb+1], busy); end
  endtask

  task automatic test_timeout();
    int rb, qb, pb;
    logic e; bit h;
    rb = res_cnt; qb = req_cnt; pb = pclr_cnt;
    silent_en = 1'b1; silent_n = 3'd2;
    run_sweep(3'd1, 3'd3, 4, e, h);
    silent_en = 1'b0;
    tests++; if (h || res_cnt - rb != 3) begin fails++; $display("FAIL timeout_count: got hung=%0b results=%0d expected hung=0 results=3", h, res_cnt - rb); end
    tests++; if (res_n_log[rb+1] !== 3'd2 || res_sum_log[rb+1] !== 13'd0 || res_to_log[rb+1] !== 1'b1) begin fails++; $display("FAIL timeout_res: got (%0d,%0d,to=%0b) expected (2,0,to=1)", res_n_log[rb+1], res_sum_log[rb+1], res_to_log[rb+1]); end
    tests++; if (res_cyc_log[rb+1] - req_cyc_log[qb+1] != 32) begin fails++; $display("FAIL timeout_length: got %0d expected 32", res_cyc_log[rb+1] - req_cyc_log[qb+1]); end
    tests++; if (res_n_log[rb+2] !== 3'd3 || res_sum_log[rb+2] !== 13'd103 || res_to_log[rb+2] !== 1'b0) begin fails++; $display("FAIL timeout_next: got (%0d,%0d,to=%0b) expected (3,103,to=0)", res_n_log[rb+2], res_sum_log[rb+2], res_to_log[rb+2]); end
    tests++; if (pclr_cnt - pb != 1) begin fails++; $display("FAIL timeout_peer_clear: got %0d expected 1", pclr_cnt - pb); end
    tests++; if (err_count !== 4'd1) begin fails++; $display("FAIL timeout_err: got %0d expected 1", err_count); end
  endtask

  task automatic test_simultaneous();
    int rb, pb;
    logic e; bit h;
    rb = res_cnt; pb = pclr_cnt;
    run_sweep(3'd4, 3'd4, 31, e, h);
    tests++; if (h || res_n_log[rb] !== 3'd4 || res_sum_log[rb] !== 13'd104 || res_to_log[rb] !== 1'b0) begin fails++; $display("FAIL simul_res: got hung=%0b (%0d,%0d,to=%0b) expected (4,104,to=0)", h, res_n_log[rb], res_sum_log[rb], res_to_log[rb]); end
    tests++; if (pclr_cnt != pb || err_count !== 4'd0) begin fails++; $display("FAIL simul_no_clear: got clears=%0d err=%0d expected 0,0", pclr_cnt - pb, err_count); end
    rb = res_cnt;
    run_sweep(3'd5, 3'd5, 32, e, h);
    tests++; if (h || res_n_log[rb] !== 3'd5 || res_sum_log[rb] !== 13'd0 || res_to_log[rb] !== 1'b1 || err_count !== 4'd1) begin fails++; $display("FAIL late_res: got hung=%0b (%0d,%0d,to=%0b) err=%0d expected (5,0,to=1) err=1", h, res_n_log[rb], res_sum_log[rb], res_to_log[rb], err_count); end
  endtask

  task automatic test_reset_midsweep();
    int rb, qb, d0;
    rb = res_cnt; qb = req_cnt; d0 = done_cnt;
    lat = 10;
    @(negedge clk); start = 1'b1; n_first = 3'd1; n_last = 3'd1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; n_first = 3'd5; n_last = 3'd5;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 500 && done_cnt == d0; i++) @(posedge clk);
    repeat (20) @(posedge clk);
    tests++; if (done_cnt - d0 != 1 || req_cnt - qb != 1 || req_n_log[qb] !== 3'd1) begin fails++; $display("FAIL busy_start_ignored: got done=%0d reqs=%0d n=%0d expected 1,1,1", done_cnt - d0, req_cnt - qb, req_n_log[qb]); end
    tests++; if (res_cnt - rb != 1 || res_sum_log[rb] !== 13'd101) begin fails++; $display("FAIL busy_start_res: got count=%0d sum=%0d expected 1,101", res_cnt - rb, res_sum_log[rb]); end
    lat = 20;
    @(negedge clk); start = 1'b1; n_first = 3'd1; n_last = 3'd3;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({req_n, req_valid, rsp_ack, peer_clear, res_n, res_sum, res_valid, res_timeout,
         err_count, busy, done} !== 37'd0) begin
      fails++;
      $display("FAIL midsweep_reset: got req_n=%0d rv=%0b busy=%0b res=(%0d,%0d) err=%0d expected all 0",
               req_n, req_valid, busy, res_n, res_sum, err_count);
    end
    @(negedge clk); reset = 1'b0;
    qb = req_cnt;
    repeat (40) @(posedge clk);
    tests++; if (req_cnt != qb || busy !== 1'b0) begin fails++; $display("FAIL midsweep_idle: got reqs=%0d busy=%0b expected 0,0", req_cnt - qb, busy); end
    tests++; if (done_busy_bad != 0) begin fails++; $display("FAIL done_busy: got %0d done cycles with busy expected 0", done_busy_bad); end
  endtask

  initial begin
    test_reset();
    test_sweep_basic();
    test_clamp_zero();
    test_range_edges();
    test_timeout();
    test_simultaneous();
    test_reset_midsweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
